// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bundle: upstream stage inputs and
// writeback/trap/instret outputs.
interface mem_wb_stage_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic [31:0]     i_inst;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_alu_res;
  logic [XLEN-1:0] i_mem_rd;
  logic [XLEN-1:0] i_mem_addr;
  logic [XLEN-1:0] i_csr_rdata;
  logic [1:0]      i_wb_sel;
  logic [4:0]      i_rd_addr;
  logic            i_reg_wr;
  logic            i_ex_ld_addr;
  logic            i_ex_st_addr;
  logic            i_mem_stall;
  logic            i_flush;
  logic            i_trap_ack;
  logic            i_instret_wr_lo;
  logic            i_instret_wr_hi;
  logic [XLEN-1:0] i_csr_wdata;

  logic            o_valid;
  logic            o_reg_wr;
  logic [4:0]      o_rd_addr;
  logic [XLEN-1:0] o_rd_data;
  logic [31:0]     o_inst;
  logic            o_exc;
  logic [3:0]      o_exc_cause;
  logic [XLEN-1:0] o_exc_pc;
  logic [XLEN-1:0] o_exc_tval;
  logic            o_trap_pending;
  logic [63:0]     o_instret;

  modport master (
    output i_valid, i_inst, i_pc, i_alu_res,
    output i_mem_rd, i_mem_addr, i_csr_rdata,
    output i_wb_sel, i_rd_addr, i_reg_wr,
    output i_ex_ld_addr, i_ex_st_addr,
    output i_mem_stall, i_flush, i_trap_ack,
    output i_instret_wr_lo, i_instret_wr_hi,
    output i_csr_wdata,
    input  o_valid, o_reg_wr, o_rd_addr,
    input  o_rd_data, o_inst, o_exc,
    input  o_exc_cause, o_exc_pc, o_exc_tval,
    input  o_trap_pending, o_instret
  );

  modport slave (
    input  i_valid, i_inst, i_pc, i_alu_res,
    input  i_mem_rd, i_mem_addr, i_csr_rdata,
    input  i_wb_sel, i_rd_addr, i_reg_wr,
    input  i_ex_ld_addr, i_ex_st_addr,
    input  i_mem_stall, i_flush, i_trap_ack,
    input  i_instret_wr_lo, i_instret_wr_hi,
    input  i_csr_wdata,
    output o_valid, o_reg_wr, o_rd_addr,
    output o_rd_data, o_inst, o_exc,
    output o_exc_cause, o_exc_pc, o_exc_tval,
    output o_trap_pending, o_instret
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with misaligned-access
// trap capture and the 64-bit instret counter.
module mem_wb_stage (
  input logic           i_clk,
  input logic           i_rst,
  mem_wb_stage_if.slave bus
);
  localparam int XLEN = 32;

  typedef enum logic {RUN, TRAP} state_t;

  state_t          state;
  logic            valid_q;
  logic            reg_wr_q;
  logic [4:0]      rd_addr_q;
  logic [XLEN-1:0] rd_data_q;
  logic [31:0]     inst_q;
  logic            exc_q;
  logic [3:0]      cause_q;
  logic [XLEN-1:0] exc_pc_q;
  logic [XLEN-1:0] exc_tval_q;
  logic [63:0]     instret_q;

  logic            accept;
  logic            exc_in;
  logic            retire;
  logic [XLEN-1:0] wb_data;
  logic [63:0]     instret_inc;
  logic [63:0]     instret_nxt;

  // accept decode, writeback select, instret next value
  always_comb begin
    accept = bus.i_valid & ~bus.i_mem_stall
           & ~bus.i_flush & (state == RUN);
    exc_in = bus.i_ex_ld_addr | bus.i_ex_st_addr;
    retire = accept & ~exc_in;
    wb_data = bus.i_alu_res;
    unique case (bus.i_wb_sel)
      2'b00: wb_data = bus.i_alu_res;
      2'b01: wb_data = bus.i_mem_rd;
      2'b10: wb_data = bus.i_pc + 32'd4;
      2'b11: wb_data = bus.i_csr_rdata;
    endcase
    instret_inc = instret_q + {63'd0, retire};
    instret_nxt = instret_inc;
    if (bus.i_instret_wr_lo)
      instret_nxt[31:0] = bus.i_csr_wdata;
    if (bus.i_instret_wr_hi)
      instret_nxt[63:32] = bus.i_csr_wdata;
  end

  // stage registers and RUN/TRAP control
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= RUN;
      valid_q    <= 1'b0;
      reg_wr_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      inst_q     <= '0;
      exc_q      <= 1'b0;
      cause_q    <= '0;
      exc_pc_q   <= '0;
      exc_tval_q <= '0;
      instret_q  <= '0;
    end else begin
      instret_q <= instret_nxt;
      unique case (state)
        RUN: begin
          if (accept && exc_in) begin
            valid_q    <= 1'b0;
            reg_wr_q   <= 1'b0;
            exc_q      <= 1'b1;
            cause_q    <= bus.i_ex_ld_addr ? 4'd4 : 4'd6;
            exc_pc_q   <= bus.i_pc;
            exc_tval_q <= bus.i_mem_addr;
            state      <= TRAP;
          end else if (accept) begin
            valid_q   <= 1'b1;
            reg_wr_q  <= bus.i_reg_wr
                       & (bus.i_rd_addr != 5'd0);
            rd_addr_q <= bus.i_rd_addr;
            rd_data_q <= wb_data;
            inst_q    <= bus.i_inst;
          end else begin
            valid_q  <= 1'b0;
            reg_wr_q <= 1'b0;
          end
        end
        TRAP: begin
          valid_q  <= 1'b0;
          reg_wr_q <= 1'b0;
          if (bus.i_trap_ack) begin
            exc_q <= 1'b0;
            state <= RUN;
          end
        end
      endcase
    end
  end

  assign bus.o_valid        = valid_q;
  assign bus.o_reg_wr       = reg_wr_q;
  assign bus.o_rd_addr      = rd_addr_q;
  assign bus.o_rd_data      = rd_data_q;
  assign bus.o_inst         = inst_q;
  assign bus.o_exc          = exc_q;
  assign bus.o_exc_cause    = cause_q;
  assign bus.o_exc_pc       = exc_pc_q;
  assign bus.o_exc_tval     = exc_tval_q;
  assign bus.o_instret      = instret_q;
  assign bus.o_trap_pending = (state == TRAP)
                            | (accept & exc_in);
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table,
// hand-written corner sequences, random vs model.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.XLEN(32)) bus ();

  mem_wb_stage dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_trap;
  bit          m_valid;
  bit          m_reg_wr;
  logic [4:0]  m_rd_addr;
  logic [31:0] m_rd_data;
  logic [31:0] m_inst;
  bit          m_exc;
  logic [3:0]  m_cause;
  logic [31:0] m_pc;
  logic [31:0] m_tval;
  logic [63:0] m_instret;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mrd;
    logic [31:0] maddr;
    logic [31:0] csr;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    logic        stall;
    logic        flush;
    logic        e_valid;
    logic        e_reg_wr;
    logic [31:0] e_data;
    logic [63:0] e_instret;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_trap    = 1'b0;
    m_valid   = 1'b0;
    m_reg_wr  = 1'b0;
    m_rd_addr = '0;
    m_rd_data = '0;
    m_inst    = '0;
    m_exc     = 1'b0;
    m_cause   = '0;
    m_pc      = '0;
    m_tval    = '0;
    m_instret = '0;
  endtask

  task automatic idle();
    bus.i_valid         = 1'b0;
    bus.i_inst          = '0;
    bus.i_pc            = '0;
    bus.i_alu_res       = '0;
    bus.i_mem_rd        = '0;
    bus.i_mem_addr      = '0;
    bus.i_csr_rdata     = '0;
    bus.i_wb_sel        = '0;
    bus.i_rd_addr       = '0;
    bus.i_reg_wr        = 1'b0;
    bus.i_ex_ld_addr    = 1'b0;
    bus.i_ex_st_addr    = 1'b0;
    bus.i_mem_stall     = 1'b0;
    bus.i_flush         = 1'b0;
    bus.i_trap_ack      = 1'b0;
    bus.i_instret_wr_lo = 1'b0;
    bus.i_instret_wr_hi = 1'b0;
    bus.i_csr_wdata     = '0;
  endtask

  function automatic logic [31:0] m_wb();
    logic [31:0] pc4;
    pc4 = bus.i_pc + 32'd4;
    case (bus.i_wb_sel)
      2'd0:    return bus.i_alu_res;
      2'd1:    return bus.i_mem_rd;
      2'd2:    return pc4;
      default: return bus.i_csr_rdata;
    endcase
  endfunction

  // behaviour of one clock edge given current inputs
  task automatic model_edge();
    bit acc;
    bit exc;
    logic [63:0] cnt;
    acc = bus.i_valid && !bus.i_mem_stall
       && !bus.i_flush && !m_trap;
    exc = bus.i_ex_ld_addr || bus.i_ex_st_addr;
    cnt = m_instret + ((acc && !exc) ? 64'd1 : 64'd0);
    if (bus.i_instret_wr_lo) cnt[31:0] = bus.i_csr_wdata;
    if (bus.i_instret_wr_hi) cnt[63:32] = bus.i_csr_wdata;
    m_instret = cnt;
    m_valid = 1'b0;
    m_reg_wr = 1'b0;
    if (m_trap) begin
      if (bus.i_trap_ack) begin
        m_trap = 1'b0;
        m_exc  = 1'b0;
      end
    end else if (acc && exc) begin
      m_exc   = 1'b1;
      m_cause = bus.i_ex_ld_addr ? 4'd4 : 4'd6;
      m_pc    = bus.i_pc;
      m_tval  = bus.i_mem_addr;
      m_trap  = 1'b1;
    end else if (acc) begin
      m_valid   = 1'b1;
      m_reg_wr  = bus.i_reg_wr && (bus.i_rd_addr != 5'd0);
      m_rd_addr = bus.i_rd_addr;
      m_inst    = bus.i_inst;
      m_rd_data = m_wb();
    end
  endtask

  task automatic chk_all();
    chk("valid", 64'(bus.o_valid), 64'(m_valid));
    chk("reg_wr", 64'(bus.o_reg_wr), 64'(m_reg_wr));
    chk("rd_addr", 64'(bus.o_rd_addr), 64'(m_rd_addr));
    chk("rd_data", 64'(bus.o_rd_data), 64'(m_rd_data));
    chk("inst", 64'(bus.o_inst), 64'(m_inst));
    chk("exc", 64'(bus.o_exc), 64'(m_exc));
    chk("cause", 64'(bus.o_exc_cause), 64'(m_cause));
    chk("exc_pc", 64'(bus.o_exc_pc), 64'(m_pc));
    chk("tval", 64'(bus.o_exc_tval), 64'(m_tval));
    chk("instret", bus.o_instret, m_instret);
  endtask

  // check trap_pending, clock one edge, check outputs
  task automatic step();
    bit pend;
    pend = m_trap || (bus.i_valid && !bus.i_mem_stall
         && !bus.i_flush
         && (bus.i_ex_ld_addr || bus.i_ex_st_addr));
    #1;
    chk("trap_pending", 64'(bus.o_trap_pending), 64'(pend));
    model_edge();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic set_instret(input logic [63:0] v);
    idle();
    bus.i_instret_wr_hi = 1'b1;
    bus.i_csr_wdata     = v[63:32];
    step();
    idle();
    bus.i_instret_wr_lo = 1'b1;
    bus.i_csr_wdata     = v[31:0];
    step();
    chk("instret_set", bus.o_instret, v);
  endtask

  task automatic retire_alu(input logic [31:0] d);
    idle();
    bus.i_valid   = 1'b1;
    bus.i_alu_res = d;
    bus.i_rd_addr = 5'd9;
    bus.i_reg_wr  = 1'b1;
  endtask

  logic [63:0] ir0;

  initial begin
    tbl[0] = '{1'b1, 32'h0002A283, 32'h1000, 32'h11,
               32'hDEADBEEF, 32'h2000, 32'h0, 2'b01,
               5'd5, 1'b1, 1'b0, 1'b0,
               1'b1, 1'b1, 32'hDEADBEEF, 64'd1};
    tbl[1] = '{1'b1, 32'h000000EF, 32'hFFFFFFFC, 32'h5,
               32'h6, 32'h0, 32'h0, 2'b10,
               5'd1, 1'b1, 1'b0, 1'b0,
               1'b1, 1'b1, 32'h0, 64'd2};
    tbl[2] = '{1'b1, 32'h0000006F, 32'h10, 32'h5,
               32'h6, 32'h0, 32'h0, 2'b10,
               5'd0, 1'b1, 1'b0, 1'b0,
               1'b1, 1'b0, 32'h14, 64'd3};
    tbl[3] = '{1'b1, 32'h00100193, 32'h20, 32'h1234,
               32'h6, 32'h0, 32'h77, 2'b00,
               5'd3, 1'b1, 1'b0, 1'b0,
               1'b1, 1'b1, 32'h1234, 64'd4};
    tbl[4] = '{1'b1, 32'hC0002373, 32'h24, 32'h1,
               32'h2, 32'h0, 32'hCAFEF00D, 2'b11,
               5'd7, 1'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 32'hCAFEF00D, 64'd5};
    tbl[5] = '{1'b0, 32'h00000013, 32'h28, 32'h9,
               32'h9, 32'h0, 32'h9, 2'b00,
               5'd4, 1'b1, 1'b0, 1'b0,
               1'b0, 1'b0, 32'hCAFEF00D, 64'd5};
    tbl[6] = '{1'b1, 32'h00000013, 32'h2C, 32'h99,
               32'h9, 32'h0, 32'h9, 2'b00,
               5'd4, 1'b1, 1'b0, 1'b1,
               1'b0, 1'b0, 32'hCAFEF00D, 64'd5};
    tbl[7] = '{1'b1, 32'h00000013, 32'h30, 32'h98,
               32'h9, 32'h0, 32'h9, 2'b00,
               5'd4, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b0, 32'hCAFEF00D, 64'd5};

    rst = 1'b1;
    idle();
    m_reset();
    #3;
    chk_all();
    chk("rst_pending", 64'(bus.o_trap_pending), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all();

    for (int i = 0; i < 8; i++) begin
      idle();
      bus.i_valid     = tbl[i].valid;
      bus.i_inst      = tbl[i].inst;
      bus.i_pc        = tbl[i].pc;
      bus.i_alu_res   = tbl[i].alu;
      bus.i_mem_rd    = tbl[i].mrd;
      bus.i_mem_addr  = tbl[i].maddr;
      bus.i_csr_rdata = tbl[i].csr;
      bus.i_wb_sel    = tbl[i].sel;
      bus.i_rd_addr   = tbl[i].rd;
      bus.i_reg_wr    = tbl[i].rw;
      bus.i_mem_stall = tbl[i].stall;
      bus.i_flush     = tbl[i].flush;
      step();
      chk($sformatf("tbl%0d_valid", i),
          64'(bus.o_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_reg_wr", i),
          64'(bus.o_reg_wr), 64'(tbl[i].e_reg_wr));
      chk($sformatf("tbl%0d_data", i),
          64'(bus.o_rd_data), 64'(tbl[i].e_data));
      chk($sformatf("tbl%0d_instret", i),
          bus.o_instret, tbl[i].e_instret);
    end

    // store misaligned trap, ignored inputs, ack
    ir0 = bus.o_instret;
    idle();
    bus.i_valid      = 1'b1;
    bus.i_ex_st_addr = 1'b1;
    bus.i_pc         = 32'h100;
    bus.i_mem_addr   = 32'h203;
    bus.i_rd_addr    = 5'd2;
    bus.i_reg_wr     = 1'b1;
    #1;
    chk("st_pending_now", 64'(bus.o_trap_pending), 64'd1);
    step();
    chk("st_exc", 64'(bus.o_exc), 64'd1);
    chk("st_cause", 64'(bus.o_exc_cause), 64'd6);
    chk("st_tval", 64'(bus.o_exc_tval), 64'h203);
    chk("st_pc", 64'(bus.o_exc_pc), 64'h100);
    for (int k = 0; k < 3; k++) begin
      retire_alu(32'h5555);
      bus.i_flush = (k == 1);
      step();
      chk("trap_valid", 64'(bus.o_valid), 64'd0);
      chk("trap_hold", 64'(bus.o_exc), 64'd1);
    end
    retire_alu(32'h6666);
    bus.i_trap_ack = 1'b1;
    step();
    chk("ack_exc", 64'(bus.o_exc), 64'd0);
    chk("ack_valid", 64'(bus.o_valid), 64'd0);
    chk("ack_instret", bus.o_instret, ir0);
    retire_alu(32'h7777);
    bus.i_trap_ack = 1'b1;
    step();
    chk("run_ack_ign", 64'(bus.o_valid), 64'd1);

    // both flags: load cause wins
    idle();
    bus.i_valid      = 1'b1;
    bus.i_ex_ld_addr = 1'b1;
    bus.i_ex_st_addr = 1'b1;
    bus.i_pc         = 32'h400;
    bus.i_mem_addr   = 32'h401;
    step();
    chk("prio_cause", 64'(bus.o_exc_cause), 64'd4);
    idle();
    bus.i_trap_ack = 1'b1;
    step();

    // three-cycle stall then single retirement
    retire_alu(32'hAAAA);
    step();
    ir0 = bus.o_instret;
    for (int k = 0; k < 3; k++) begin
      retire_alu(32'hBBBB);
      bus.i_mem_stall = 1'b1;
      step();
      chk("stall_valid", 64'(bus.o_valid), 64'd0);
      chk("stall_hold", 64'(bus.o_rd_data), 64'hAAAA);
    end
    retire_alu(32'hBBBB);
    step();
    chk("unstall_data", 64'(bus.o_rd_data), 64'hBBBB);
    idle();
    step();
    chk("single_retire", bus.o_instret, ir0 + 64'd1);

    // instret carry, CSR overrides, full wrap
    set_instret(64'h0000_0000_FFFF_FFFF);
    retire_alu(32'h1);
    step();
    chk("carry", bus.o_instret, 64'h1_0000_0000);
    set_instret(64'h0000_0000_FFFF_FFFF);
    retire_alu(32'h2);
    bus.i_instret_wr_lo = 1'b1;
    bus.i_csr_wdata     = 32'h10;
    step();
    chk("wr_lo_carry", bus.o_instret, 64'h1_0000_0010);
    retire_alu(32'h3);
    bus.i_instret_wr_lo = 1'b1;
    bus.i_instret_wr_hi = 1'b1;
    bus.i_csr_wdata     = 32'hFFFF_FFFF;
    step();
    chk("wr_both", bus.o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    retire_alu(32'h4);
    step();
    chk("wrap64", bus.o_instret, 64'd0);

    // asynchronous reset during TRAP
    idle();
    bus.i_valid      = 1'b1;
    bus.i_ex_ld_addr = 1'b1;
    bus.i_pc         = 32'h800;
    bus.i_mem_addr   = 32'h802;
    step();
    chk("pre_rst_exc", 64'(bus.o_exc), 64'd1);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_exc", 64'(bus.o_exc), 64'd0);
    m_reset();
    chk_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    retire_alu(32'h1357);
    step();
    chk("post_rst_valid", 64'(bus.o_valid), 64'd1);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.i_valid      = ($urandom_range(0, 3) != 0);
      bus.i_inst       = $urandom;
      bus.i_pc         = ($urandom_range(0, 7) == 0)
                       ? 32'hFFFF_FFFC : $urandom;
      bus.i_alu_res    = $urandom;
      bus.i_mem_rd     = $urandom;
      bus.i_mem_addr   = $urandom;
      bus.i_csr_rdata  = $urandom;
      bus.i_wb_sel     = 2'($urandom_range(0, 3));
      bus.i_rd_addr    = 5'($urandom_range(0, 31));
      bus.i_reg_wr     = 1'($urandom_range(0, 1));
      bus.i_ex_ld_addr = ($urandom_range(0, 11) == 0);
      bus.i_ex_st_addr = ($urandom_range(0, 11) == 0);
      bus.i_mem_stall  = ($urandom_range(0, 6) == 0);
      bus.i_flush      = ($urandom_range(0, 9) == 0);
      bus.i_trap_ack   = ($urandom_range(0, 2) == 0);
      bus.i_instret_wr_lo = ($urandom_range(0, 19) == 0);
      bus.i_instret_wr_hi = ($urandom_range(0, 19) == 0);
      bus.i_csr_wdata  = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
